div: RTL
========

# div

Multi-cycle 32-bit radix-2 restoring divider; the responder side of the EX-stage serial divide handshake. EX drives `start_i`/`annul_i`/operands and stalls the pipeline until `ready_o`, then writes `result_o` into HI/LO. The block computes one quotient bit per cycle and supports signed and unsigned division. It lives between EX and the HI/LO path, clocked with the pipeline.

## Interface
Parameters:
- none; width fixed at 32 (`RegBus`), result 64 (`DoubleRegBus`).

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-low (asserted when 0).
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request; held high by EX while waiting (`DivStart`/`DivStop`).
- `annul_i`  in  1  abort in-flight division.
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}; registered.
- `ready_o`  out  1  `DivResReady` when `result_o` is valid; registered.

## Operation
- States: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
- Reset (async, `rst`=0): state `DivFree`, cnt 0, `ready_o`=`DivResNotReady`, `result_o`=0, working regs 0.
- `DivFree`:
  - `start_i`=1, `annul_i`=0, divisor 0 → `DivByZero`.
  - `start_i`=1, `annul_i`=0, divisor ≠ 0 → `DivOn`, cnt=0.
    - Latch |op1| and |op2| if signed, else raw operands.
    - Latch quotient sign = op1[31]^op2[31] and remainder sign = op1[31] (signed only).
  - Otherwise hold; `ready_o`=0, `result_o`=0.
- `DivByZero`: next edge → `DivEnd`, `result_o`=0, `ready_o`=1.
- `DivOn`:
  - `annul_i`=1 → `DivFree` at that edge; no result, `ready_o` stays 0.
  - Else if cnt<32: one restoring step per edge.
    - 65-bit working reg {rem, quo}.
    - Trial = rem[31:0]<<1 | quo[31], minus divisor (33-bit).
    - Non-negative → rem=trial, quo bit=1; else rem shifted, quo bit=0. cnt++.
  - cnt==32: apply sign fix.
    - Quotient negated if quotient sign; remainder negated if remainder sign.
    - Latch into `result_o`, set `ready_o`=1, go to `DivEnd`.
- `DivEnd`:
  - `start_i`=1: hold `result_o` and `ready_o` stable.
  - `start_i`=0 → `DivFree`, `ready_o`=0, `result_o`=0.
  - `annul_i` is ignored here; EX raises it together with dropping `start_i`.
- Arithmetic:
  - Two's complement; negate = ~x+1.
  - Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0; no trap.
  - Remainder sign always follows the dividend.

## Timing
- Start accepted at edge E0 (`DivFree`); steps at E1..E32; result and `ready_o` registered at E33. `ready_o` is high 33 cycles after the accepting edge.
- Divide-by-zero: `ready_o` high 2 edges after E0.
- `ready_o` falls on the first edge with `start_i`=0 in `DivEnd`. A new start is accepted at the following `DivFree` edge at the earliest, so there is one idle cycle between back-to-back divides.
- Operands are sampled only at E0; changes during `DivOn` have no effect.
- Annul takes effect at the same edge it is sampled; reset mid-operation returns to the reset state immediately.

## Structure
- `defines.v` owns:
  - state encodings `DivFree`=2'b00, `DivByZero`=2'b01, `DivOn`=2'b10, `DivEnd`=2'b11;
  - `DivResReady`/`DivResNotReady`, `DivStart`/`DivStop`;
  - `RegBus`, `DoubleRegBus`, `ZeroWord`, `ZeroDoubleWord`.
- Single module; no sub-module. The step subtraction is an inline combinational 33-bit subtract.

## Test plan
- Unsigned 100/7, hold `start_i` → `ready_o` at E33, `result_o`=0x00000002_0000000E; drop `start_i` → `ready_o`=0 next edge.
- Signed −7/2 (0xFFFFFFF9/0x00000002) → `result_o`=0xFFFFFFFF_FFFFFFFD. Same operands unsigned → quotient 0x7FFFFFFC, remainder 1.
- Divisor 0 (op1=0x12345678) → `ready_o` at E2, `result_o`=0.
- Annul at cycle 10 of `DivOn` → `ready_o` never rises, state `DivFree`. Immediate new 0xFFFFFFFF/1 unsigned → 0x00000000_FFFFFFFF at E33.
- Signed 0x80000000/0xFFFFFFFF → 0x00000000_80000000. `start_i` held 5 cycles after ready → `result_o` stable throughout.
- `rst` low at step 20 → `ready_o`=0 and `result_o`=0 asynchronously. After release, 9/3 → 0x00000000_00000003.

Source files
------------

// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared constants and helpers for the serial restoring divider
//               (bus widths, FSM encodings, handshake levels, negation).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  // Operand and result bus widths
  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  localparam logic [REG_BUS-1:0]        ZERO_WORD        = '0;
  localparam logic [DOUBLE_REG_BUS-1:0] ZERO_DOUBLE_WORD = '0;

  // Divider FSM encodings
  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  // Handshake levels shared with the EX stage
  localparam logic DIV_RES_READY     = 1'b1;
  localparam logic DIV_RES_NOT_READY = 1'b0;
  localparam logic DIV_START         = 1'b1;
  localparam logic DIV_STOP          = 1'b0;

  // One quotient bit is produced per step; this many steps finish a divide
  localparam logic [5:0] DIV_STEPS = 6'd32;

  // Two's-complement negation
  function automatic logic [REG_BUS-1:0] negate(input logic [REG_BUS-1:0] x);
    return ~x + REG_BUS'(1);
  endfunction

  // Magnitude of an operand: absolute value when signed, raw bits otherwise.
  // The most negative value maps onto itself, which is the correct unsigned
  // magnitude 2^31.
  function automatic logic [REG_BUS-1:0] magnitude(input logic             is_signed,
                                                   input logic [REG_BUS-1:0] x);
    return (is_signed && x[REG_BUS-1]) ? negate(x) : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div.sv
// ============================================================================
// Module      : div
// Description : Multi-cycle 32-bit radix-2 restoring divider, signed and
//               unsigned, answering the EX-stage start/annul/ready handshake.
//               Result is {remainder, quotient}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div
  import div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o
);

  logic [1:0]         state;
  logic [5:0]         cnt;

  // Working register {rem, quo}: the dividend magnitude is shifted out of quo
  // one bit per step while quotient bits are shifted in behind it.
  logic [REG_BUS-1:0] work_rem;
  logic [REG_BUS-1:0] work_quo;
  logic [REG_BUS-1:0] divisor;
  logic               quo_neg;
  logic               rem_neg;

  logic [REG_BUS:0]   trial;
  logic [REG_BUS-1:0] rem_next;
  logic [REG_BUS-1:0] quo_next;
  logic [REG_BUS-1:0] quo_fixed;
  logic [REG_BUS-1:0] rem_fixed;
  logic               accept;

  assign accept = (start_i == DIV_START) && !annul_i;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and try subtracting the divisor. The partial remainder is
  // always below the divisor, so the shifted value fits 33 bits and the
  // subtraction sign bit tells whether the divisor fits.
  always_comb begin
    trial = {work_rem, work_quo[REG_BUS-1]} - {1'b0, divisor};
    if (!trial[REG_BUS]) begin
      rem_next = trial[REG_BUS-1:0];
      quo_next = {work_quo[REG_BUS-2:0], 1'b1};
    end else begin
      rem_next = {work_rem[REG_BUS-2:0], work_quo[REG_BUS-1]};
      quo_next = {work_quo[REG_BUS-2:0], 1'b0};
    end
  end

  // Sign correction applied once all magnitude bits are produced; the
  // remainder takes the dividend's sign, the quotient the XOR of both.
  always_comb begin
    quo_fixed = quo_neg ? negate(work_quo) : work_quo;
    rem_fixed = rem_neg ? negate(work_rem) : work_rem;
  end

  // Handshake FSM, step counter, working registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= 6'd0;
      work_rem <= ZERO_WORD;
      work_quo <= ZERO_WORD;
      divisor  <= ZERO_WORD;
      quo_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      result_o <= ZERO_DOUBLE_WORD;
      ready_o  <= DIV_RES_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= DIV_RES_NOT_READY;
          result_o <= ZERO_DOUBLE_WORD;
          if (accept) begin
            if (opdata2_i == ZERO_WORD) begin
              state <= DIV_BY_ZERO;
            end else begin
              // Operands are captured only here; later changes are ignored
              state    <= DIV_ON;
              cnt      <= 6'd0;
              work_rem <= ZERO_WORD;
              work_quo <= magnitude(signed_div_i, opdata1_i);
              divisor  <= magnitude(signed_div_i, opdata2_i);
              quo_neg  <= signed_div_i & (opdata1_i[REG_BUS-1] ^ opdata2_i[REG_BUS-1]);
              rem_neg  <= signed_div_i & opdata1_i[REG_BUS-1];
            end
          end
        end

        DIV_BY_ZERO: begin
          // Division by zero reports an all-zero result, no trap
          state    <= DIV_END;
          result_o <= ZERO_DOUBLE_WORD;
          work_rem <= ZERO_WORD;
          work_quo <= ZERO_WORD;
        end

        DIV_ON: begin
          if (annul_i) begin
            state   <= DIV_FREE;
            ready_o <= DIV_RES_NOT_READY;
          end else if (cnt != DIV_STEPS) begin
            work_rem <= rem_next;
            work_quo <= quo_next;
            cnt      <= cnt + 6'd1;
          end else begin
            result_o <= {rem_fixed, quo_fixed};
            ready_o  <= DIV_RES_READY;
            state    <= DIV_END;
          end
        end

        DIV_END: begin
          // Result is held while EX keeps start high; annul is not looked at
          if (start_i == DIV_STOP) begin
            state    <= DIV_FREE;
            ready_o  <= DIV_RES_NOT_READY;
            result_o <= ZERO_DOUBLE_WORD;
          end else begin
            ready_o  <= DIV_RES_READY;
          end
        end

        default: begin
          state <= DIV_FREE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
